// File: rtl/axi_llc_pkg.sv
// rtl/axi_llc_pkg.sv - shared LLC types and constants for the way scrub scheduler
package axi_llc_pkg;

    localparam int unsigned DataMacroLatency = 2;

    // Outcome of a scrub arrives after the data macro read plus the ECC check stages.
    localparam int unsigned ScrubObserveCycles = DataMacroLatency + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ARM     = 2'd2,
        OBSERVE = 2'd3
    } scrub_sched_state_e;

endpackage

// File: rtl/axi_llc_way_scrub_sched_popcount.sv
// rtl/axi_llc_way_scrub_sched_popcount.sv - population count of an error pulse vector
module axi_llc_way_scrub_sched_popcount #(
    parameter int unsigned Width      = 4,
    parameter int unsigned CountWidth = $clog2(Width + 1)
) (
    input  logic [Width-1:0]      data,
    output logic [CountWidth-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < Width; i++) begin
            count = count + CountWidth'(data[i]);
        end
    end

endmodule

// File: rtl/axi_llc_way_scrub_sched.sv
// rtl/axi_llc_way_scrub_sched.sv - round-robin ECC scrub trigger scheduler with error accounting
module axi_llc_way_scrub_sched
    import axi_llc_pkg::*;
#(
    parameter int unsigned NumWays       = 8,
    parameter int unsigned NumGran       = 1,
    parameter int unsigned IntervalWidth = 16,
    parameter int unsigned ObserveCycles = ScrubObserveCycles,
    parameter int unsigned CntWidth      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [IntervalWidth-1:0]     interval_i,
    input  logic                         clear_i,
    input  logic [NumWays-1:0]           way_busy_i,
    output logic [NumWays*NumGran-1:0]   scrub_trigger_o,
    input  logic [NumWays*NumGran-1:0]   scrubber_fix_i,
    input  logic [NumWays*NumGran-1:0]   scrub_uncorrectable_i,
    output logic [CntWidth-1:0]          fix_cnt_o,
    output logic [CntWidth-1:0]          unc_cnt_o,
    output logic [NumWays-1:0]           fault_ways_o,
    output logic                         sweep_done_o,
    output logic                         busy_o
);

    localparam int unsigned NumPairs = NumWays * NumGran;
    localparam int unsigned PtrWidth = (NumPairs > 1) ? $clog2(NumPairs) : 1;
    localparam int unsigned ObsWidth = (ObserveCycles > 1) ? $clog2(ObserveCycles) : 1;
    localparam int unsigned PopWidth = $clog2(NumPairs + 1);
    localparam int unsigned SumWidth = CntWidth + PopWidth;

    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(NumPairs - 1);
    localparam logic [ObsWidth-1:0] ObsLoad = ObsWidth'(ObserveCycles - 1);
    localparam logic [SumWidth-1:0] CntMax  = {{PopWidth{1'b0}}, {CntWidth{1'b1}}};

    scrub_sched_state_e state_q, state_d;
    logic [IntervalWidth-1:0] ival_q, ival_d;
    logic [ObsWidth-1:0]      obs_q, obs_d;
    logic [PtrWidth-1:0]      ptr_q, ptr_d;
    logic [NumPairs-1:0]      trig_q, trig_d;
    logic                     sweep_q, sweep_d;

    logic [NumPairs-1:0] pair_busy;
    logic [NumWays-1:0]  unc_way;
    logic                fire;

    // Flat pair index p maps to way p / NumGran.
    for (genvar p = 0; p < NumPairs; p++) begin : g_pair
        assign pair_busy[p] = way_busy_i[p / NumGran];
    end

    for (genvar w = 0; w < NumWays; w++) begin : g_way
        assign unc_way[w] = |scrub_uncorrectable_i[w*NumGran +: NumGran];
    end

    // Error accounting
    logic [PopWidth-1:0] fix_pop, unc_pop;
    logic [CntWidth-1:0] fix_cnt_q, unc_cnt_q;
    logic [NumWays-1:0]  fault_q;
    logic [SumWidth-1:0] fix_sum, unc_sum;
    logic [CntWidth-1:0] fix_sat, unc_sat;

    axi_llc_way_scrub_sched_popcount #(
        .Width      (NumPairs),
        .CountWidth (PopWidth)
    ) i_fix_popcount (
        .data  (scrubber_fix_i),
        .count (fix_pop)
    );

    axi_llc_way_scrub_sched_popcount #(
        .Width      (NumPairs),
        .CountWidth (PopWidth)
    ) i_unc_popcount (
        .data  (scrub_uncorrectable_i),
        .count (unc_pop)
    );

    assign fix_sum = {{PopWidth{1'b0}}, fix_cnt_q} + {{CntWidth{1'b0}}, fix_pop};
    assign unc_sum = {{PopWidth{1'b0}}, unc_cnt_q} + {{CntWidth{1'b0}}, unc_pop};
    assign fix_sat = (fix_sum > CntMax) ? {CntWidth{1'b1}} : fix_sum[CntWidth-1:0];
    assign unc_sat = (unc_sum > CntMax) ? {CntWidth{1'b1}} : unc_sum[CntWidth-1:0];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ival_q    <= '0;
            obs_q     <= '0;
            ptr_q     <= '0;
            trig_q    <= '0;
            sweep_q   <= 1'b0;
            fix_cnt_q <= '0;
            unc_cnt_q <= '0;
            fault_q   <= '0;
        end else begin
            state_q <= state_d;
            ival_q  <= ival_d;
            obs_q   <= obs_d;
            ptr_q   <= ptr_d;
            trig_q  <= trig_d;
            sweep_q <= sweep_d;
            if (clear_i) begin
                fix_cnt_q <= '0;
                unc_cnt_q <= '0;
                fault_q   <= '0;
            end else begin
                fix_cnt_q <= fix_sat;
                unc_cnt_q <= unc_sat;
                fault_q   <= fault_q | unc_way;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ival_d  = ival_q;
        obs_d   = obs_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = WAIT;
                    ival_d  = interval_i;
                end
            end
            WAIT: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (ival_q == '0) begin
                    state_d = ARM;
                end else begin
                    ival_d = ival_q - IntervalWidth'(1);
                end
            end
            ARM: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (!pair_busy[ptr_q]) begin
                    state_d = OBSERVE;
                    obs_d   = ObsLoad;
                end
            end
            OBSERVE: begin
                // The observation window always runs to completion, even when disabled.
                if (obs_q == '0) begin
                    ptr_d = (ptr_q == LastPtr) ? '0 : ptr_q + PtrWidth'(1);
                    if (enable_i) begin
                        state_d = WAIT;
                        ival_d  = interval_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    obs_d = obs_q - ObsWidth'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        fire    = (state_q == ARM) && enable_i && !pair_busy[ptr_q];
        trig_d  = '0;
        trig_d[ptr_q] = fire;
        sweep_d = (state_q == OBSERVE) && (obs_q == '0) && (ptr_q == LastPtr);
        busy_o  = (state_q != IDLE);
    end

    assign scrub_trigger_o = trig_q;
    assign sweep_done_o    = sweep_q;
    assign fix_cnt_o       = fix_cnt_q;
    assign unc_cnt_o       = unc_cnt_q;
    assign fault_ways_o    = fault_q;

endmodule

// File: tb/tb_axi_llc_way_scrub_sched.sv
// tb/tb_axi_llc_way_scrub_sched.sv - self-checking bench for the way scrub scheduler
module tb_axi_llc_way_scrub_sched;

    localparam int NW = 2;
    localparam int NG = 2;
    localparam int NP = NW * NG;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [15:0]   interval;
    logic          clear;
    logic [NW-1:0] way_busy;
    logic [NP-1:0] trig;
    logic [NP-1:0] fix;
    logic [NP-1:0] unc;
    logic [CW-1:0] fix_cnt;
    logic [CW-1:0] unc_cnt;
    logic [NW-1:0] fault;
    logic          sweep;
    logic          busy;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        int bitn;
        int at;
    } trig_exp_t;

    trig_exp_t exp_trig[$];
    int        exp_sweep[$];

    typedef struct {
        logic [NP-1:0] fix;
        logic [NP-1:0] unc;
        logic          clr;
        logic [CW-1:0] exp_fix;
        logic [CW-1:0] exp_unc;
        logic [NW-1:0] exp_fault;
    } cnt_vec_t;

    axi_llc_way_scrub_sched #(
        .NumWays       (NW),
        .NumGran       (NG),
        .IntervalWidth (16),
        .ObserveCycles (4),
        .CntWidth      (CW)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .enable_i              (enable),
        .interval_i            (interval),
        .clear_i               (clear),
        .way_busy_i            (way_busy),
        .scrub_trigger_o       (trig),
        .scrubber_fix_i        (fix),
        .scrub_uncorrectable_i (unc),
        .fix_cnt_o             (fix_cnt),
        .unc_cnt_o             (unc_cnt),
        .fault_ways_o          (fault),
        .sweep_done_o          (sweep),
        .busy_o                (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every trigger and sweep pulse must match a queued expectation.
    always @(negedge clk) begin
        if (trig != '0) begin
            chk("trig_onehot", $countones(trig), 1);
            if (exp_trig.size() == 0) begin
                chk("trig_unexpected", {28'd0, trig}, 0);
            end else begin
                trig_exp_t e;
                e = exp_trig.pop_front();
                chk("trig_bit", {28'd0, trig}, 32'(1 << e.bitn));
                chk("trig_cycle", cyc, e.at);
            end
        end
        if (sweep) begin
            if (exp_sweep.size() == 0) begin
                chk("sweep_unexpected", 1, 0);
            end else begin
                chk("sweep_cycle", cyc, exp_sweep.pop_front());
            end
        end
    end

    cnt_vec_t vecs[7];

    initial begin
        int k;
        int m;
        int r;

        vecs[0] = '{fix: 4'b0101, unc: 4'b0000, clr: 1'b0, exp_fix: 4'd2, exp_unc: 4'd0, exp_fault: 2'b00};
        vecs[1] = '{fix: 4'b0000, unc: 4'b1000, clr: 1'b0, exp_fix: 4'd2, exp_unc: 4'd1, exp_fault: 2'b10};
        vecs[2] = '{fix: 4'b1111, unc: 4'b0001, clr: 1'b1, exp_fix: 4'd0, exp_unc: 4'd0, exp_fault: 2'b00};
        vecs[3] = '{fix: 4'b1111, unc: 4'b0011, clr: 1'b0, exp_fix: 4'd4, exp_unc: 4'd2, exp_fault: 2'b01};
        vecs[4] = '{fix: 4'b0000, unc: 4'b0100, clr: 1'b0, exp_fix: 4'd4, exp_unc: 4'd3, exp_fault: 2'b11};
        vecs[5] = '{fix: 4'b0000, unc: 4'b0000, clr: 1'b1, exp_fix: 4'd0, exp_unc: 4'd0, exp_fault: 2'b00};
        vecs[6] = '{fix: 4'b0000, unc: 4'b0010, clr: 1'b0, exp_fix: 4'd0, exp_unc: 4'd1, exp_fault: 2'b01};

        rst = 1'b1; enable = 1'b0; interval = 16'd3; clear = 1'b0;
        way_busy = '0; fix = '0; unc = '0;
        step(3);
        chk("rst_trig", {28'd0, trig}, 0);
        chk("rst_fix", {28'd0, fix_cnt}, 0);
        chk("rst_unc", {28'd0, unc_cnt}, 0);
        chk("rst_fault", {30'd0, fault}, 0);
        chk("rst_sweep", {31'd0, sweep}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        step(1);
        chk("idle_busy", {31'd0, busy}, 0);

        for (int i = 0; i < 7; i++) begin
            fix = vecs[i].fix; unc = vecs[i].unc; clear = vecs[i].clr;
            step(1);
            chk($sformatf("vec%0d_fix", i), {28'd0, fix_cnt}, {28'd0, vecs[i].exp_fix});
            chk($sformatf("vec%0d_unc", i), {28'd0, unc_cnt}, {28'd0, vecs[i].exp_unc});
            chk($sformatf("vec%0d_fault", i), {30'd0, fault}, {30'd0, vecs[i].exp_fault});
        end
        fix = '0; unc = '0; clear = 1'b0;

        for (int i = 0; i < 20; i++) begin
            fix = 4'b0001;
            step(1);
            chk($sformatf("sat_fix%0d", i), {28'd0, fix_cnt}, (i + 1 > 15) ? 15 : i + 1);
        end
        fix = 4'b0001; clear = 1'b1;
        step(1);
        chk("clr_wins_fix", {28'd0, fix_cnt}, 0);
        chk("clr_wins_fault", {30'd0, fault}, 0);
        fix = 4'b0011; unc = 4'b0100; clear = 1'b0;
        step(1);
        fix = '0; unc = '0;
        chk("post_fix", {28'd0, fix_cnt}, 2);
        chk("post_unc", {28'd0, unc_cnt}, 1);
        chk("post_fault", {30'd0, fault}, 2'b10);

        // Full sweep and a second partial sweep, spacing 1 + 4 + 3 + 1 = 9.
        k = cyc;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) exp_trig.push_back('{bitn: i % 4, at: k + 6 + 9 * i});
        exp_sweep.push_back(k + 37);
        step(52);
        enable = 1'b0;
        step(2);
        chk("obs_completes_busy", {31'd0, busy}, 1);
        step(1);
        chk("disabled_idle", {31'd0, busy}, 0);
        step(3);
        chk("stays_idle", {31'd0, busy}, 0);

        // Re-enable with way 1 busy: pair 2 must stall in ARM.
        m = cyc;
        enable = 1'b1;
        way_busy = 2'b10;
        exp_trig.push_back('{bitn: 2, at: m + 21});
        exp_trig.push_back('{bitn: 3, at: m + 30});
        exp_sweep.push_back(m + 34);
        exp_trig.push_back('{bitn: 0, at: m + 39});
        step(10);
        chk("stall_busy", {31'd0, busy}, 1);
        chk("stall_no_trig", {28'd0, trig}, 0);
        step(10);
        way_busy = '0;
        step(19);
        chk("pre_rst_trig", {28'd0, trig}, 4'b0001);
        chk("pre_rst_fix", {28'd0, fix_cnt}, 2);
        chk("pre_rst_fault", {30'd0, fault}, 2'b10);
        rst = 1'b1;
        step(1);
        chk("midrst_trig", {28'd0, trig}, 0);
        chk("midrst_fix", {28'd0, fix_cnt}, 0);
        chk("midrst_unc", {28'd0, unc_cnt}, 0);
        chk("midrst_fault", {30'd0, fault}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_sweep", {31'd0, sweep}, 0);
        rst = 1'b0;
        r = cyc;
        exp_trig.push_back('{bitn: 0, at: r + 6});
        step(8);
        enable = 1'b0;
        step(6);

        chk("trig_queue_drained", exp_trig.size(), 0);
        chk("sweep_queue_drained", exp_sweep.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
